keypad_debounce: RTL and testbench

- Sits directly upstream of the clock/time-setting block.
- Samples the raw 10-key active-low keypad (one line per digit 0–9), synchronizes and debounces it, and rejects multi-key presses.
- Emits one single-cycle event per press, carrying the binary digit code.
- Also drives a cleaned 10-bit active-low vector, so the downstream block sees exactly one stable press-to-release transition per physical keystroke.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_sync.sv | 25 ++
 rtl/keypad_debounce.sv | 156 +++++++++++++++
 tb/tb_keypad_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 10-key keypad front end.
// Holds the debounce FSM state encoding, the idle (no key) vector constant,
// the active-low one-hot to digit code conversion and the single-key classifier.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [9:0] KEY_NONE = 10'h3FF;

  // Index of the (lowest) zero bit; 0 when no bit is low.
  function automatic logic [3:0] onehot_low_to_code(input logic [9:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (!v[i]) code = 4'(i);
    end
    return code;
  endfunction

  // True when exactly one line is pulled low.
  function automatic logic is_single(input logic [9:0] v);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      if (!v[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer, both stages reset to all-ones (idle keys).
// Latency: 2 clk edges from d to q. No backpressure; free-running.
// Ports: clk, rst (async active-low), d (raw async input), q (synchronized).
module keypad_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronizes/debounces an active-low 10-key pad, rejects multi-key.
// Latency: press stable from edge 0 -> key_valid after edge DEBOUNCE_CNT+2; release same.
// Backpressure: none; key_valid is a one-cycle event the consumer must take.
// Ports: clk, rst (async active-low), keypad (raw, active-low), key_valid (event),
//   key_code (digit, held between events), key_held (accepted key down),
//   keypad_clean (debounced active-low vector, 10'h3FF when nothing accepted).
// Optional macro KEYPAD_REPEAT_EN: auto-repeat while held (REPEAT_DELAY, REPEAT_RATE).
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 20
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [9:0] keypad_clean
);

  localparam logic [7:0] CNT_TGT = 8'(DEBOUNCE_CNT);

  logic [9:0] sync;
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic [9:0] cand, cand_nxt;
  logic       valid_nxt;
  logic [3:0] code_nxt;
  logic [9:0] clean_nxt;
  logic       sync_none, sync_single;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [9:0] RPT_DLY = 10'(REPEAT_DELAY);
  localparam logic [9:0] RPT_RLD = 10'(REPEAT_DELAY - REPEAT_RATE);
  logic [9:0] rpt, rpt_nxt;
`endif

  keypad_sync #(.W(10)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (keypad),
    .q   (sync)
  );

  assign sync_none   = (sync == KEY_NONE);
  assign sync_single = is_single(sync);
  assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign key_held    = (state == PRESSED) || (state == RELEASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      cand         <= KEY_NONE;
      key_valid    <= 1'b0;
      key_code     <= 4'd0;
      keypad_clean <= KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
      rpt          <= 10'd0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cand         <= cand_nxt;
      key_valid    <= valid_nxt;
      key_code     <= code_nxt;
      keypad_clean <= clean_nxt;
`ifdef KEYPAD_REPEAT_EN
      rpt          <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    valid_nxt = 1'b0;
    code_nxt  = key_code;
    clean_nxt = keypad_clean;
`ifdef KEYPAD_REPEAT_EN
    // Anything other than staying in PRESSED clears the repeat timer.
    rpt_nxt   = 10'd0;
`endif
    case (state)
      IDLE: begin
        if (sync_single) begin
          state_nxt = DEBOUNCE;
          cand_nxt  = sync;
          cnt_nxt   = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (sync != cand) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          cand_nxt  = KEY_NONE;
        end else if (cnt >= CNT_TGT) begin
          // Counter already shows DEBOUNCE_CNT matching samples: accept.
          state_nxt = PRESSED;
          cnt_nxt   = 8'd0;
          valid_nxt = 1'b1;
          code_nxt  = onehot_low_to_code(cand);
          clean_nxt = cand;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (sync != cand) begin
          state_nxt = RELEASE;
          cnt_nxt   = sync_none ? 8'd1 : 8'd0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          // Reload to DELAY-RATE so later repeats land every REPEAT_RATE cycles.
          if (rpt + 10'd1 == RPT_DLY) begin
            valid_nxt = 1'b1;
            rpt_nxt   = RPT_RLD;
          end else begin
            rpt_nxt = rpt + 10'd1;
          end
`endif
        end
      end
      RELEASE: begin
        if (sync_none) begin
          if (cnt >= CNT_TGT) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            cand_nxt  = KEY_NONE;
            clean_nxt = KEY_NONE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else if (sync == cand) begin
          state_nxt = PRESSED;
          cnt_nxt   = 8'd0;
        end else begin
          // A different key or a chord: keep waiting for a clean full release.
          cnt_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed-vector bench for keypad_debounce (DEBOUNCE_CNT=20).
// Edge indices are counted from the first clock edge after the raw keys change.
module tb_keypad_debounce;

  logic       clk;
  logic       rst;
  logic [9:0] keypad;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [9:0] keypad_clean;

  int n_cmp = 0;
  int n_err = 0;

  keypad_debounce #(.DEBOUNCE_CNT(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .keypad       (keypad),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_held     (key_held),
    .keypad_clean (keypad_clean)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive keys, then observe n edges (#1 after each). Reports pulse count,
  // edge index of first/last key_valid, code and key_held at the first pulse,
  // edge index of first keypad_clean change and key_held at that point.
  task automatic run(input logic [9:0] keys, input int n,
                     output int pulses, output int first_at, output int last_at,
                     output logic [3:0] code, output logic held_v,
                     output int clean_at, output logic held_c);
    logic [9:0] clean0;
    keypad   = keys;
    clean0   = keypad_clean;
    pulses   = 0;
    first_at = -1;
    last_at  = -1;
    code     = 4'd0;
    held_v   = 1'b0;
    clean_at = -1;
    held_c   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) begin
        if (pulses == 0) begin
          first_at = i;
          code     = key_code;
          held_v   = key_held;
        end
        pulses++;
        last_at = i;
      end
      if (clean_at < 0 && keypad_clean != clean0) begin
        clean_at = i;
        held_c   = key_held;
      end
    end
  endtask

  int         p, f, l, c_at, tot;
  logic [3:0] cd;
  logic       hv, hc;

  initial begin
    rst    = 1'b0;
    keypad = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code",  32'(key_code), 32'd0);
    chk("rst_held",  32'(key_held), 32'd0);
    chk("rst_clean", 32'(keypad_clean), 32'h3FF);
    rst = 1'b1;
    run(10'h3FF, 5, p, f, l, cd, hv, c_at, hc);

    // Clean press of digit 7, then release.
    run(10'h37F, 50, p, f, l, cd, hv, c_at, hc);
    chk("d7_pulses",   32'(p), 32'd1);
    chk("d7_at",       32'(f), 32'd22);
    chk("d7_code",     32'(cd), 32'd7);
    chk("d7_held",     32'(hv), 32'd1);
    chk("d7_clean_at", 32'(c_at), 32'd22);
    chk("d7_clean",    32'(keypad_clean), 32'h37F);
    chk("d7_code_hold", 32'(key_code), 32'd7);
    run(10'h3FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d7_rel_pulses", 32'(p), 32'd0);
    chk("d7_rel_at",     32'(c_at), 32'd22);
    chk("d7_rel_heldc",  32'(hc), 32'd0);
    chk("d7_rel_clean",  32'(keypad_clean), 32'h3FF);
    chk("d7_rel_code",   32'(key_code), 32'd7);

    // Press shorter than the debounce window: no event.
    run(10'h3FB, 20, p, f, l, cd, hv, c_at, hc);
    tot = p;
    run(10'h3FF, 30, p, f, l, cd, hv, c_at, hc);
    tot += p;
    chk("short_pulses", 32'(tot), 32'd0);
    chk("short_clean",  32'(keypad_clean), 32'h3FF);

    // Digit 3 bouncing 5 on / 3 off for 40 cycles, then stable.
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      run(10'h3F7, 5, p, f, l, cd, hv, c_at, hc);
      tot += p;
      run(10'h3FF, 3, p, f, l, cd, hv, c_at, hc);
      tot += p;
    end
    chk("d3_bounce_pulses", 32'(tot), 32'd0);
    run(10'h3F7, 40, p, f, l, cd, hv, c_at, hc);
    chk("d3_pulses", 32'(p), 32'd1);
    chk("d3_at",     32'(f), 32'd22);
    chk("d3_code",   32'(cd), 32'd3);
    run(10'h3FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d3_rel_clean", 32'(keypad_clean), 32'h3FF);

    // Digits 1 and 2 together: rejected.
    run(10'h3F9, 40, p, f, l, cd, hv, c_at, hc);
    chk("multi_pulses", 32'(p), 32'd0);
    chk("multi_clean",  32'(keypad_clean), 32'h3FF);
    chk("multi_held",   32'(key_held), 32'd0);
    run(10'h3FF, 30, p, f, l, cd, hv, c_at, hc);

    // Hold 4, add 5, drop 4, then release all.
    run(10'h3EF, 30, p, f, l, cd, hv, c_at, hc);
    chk("d4_pulses", 32'(p), 32'd1);
    chk("d4_code",   32'(cd), 32'd4);
    run(10'h3CF, 30, p, f, l, cd, hv, c_at, hc);
    chk("d45_pulses", 32'(p), 32'd0);
    chk("d45_clean",  32'(keypad_clean), 32'h3EF);
    run(10'h3DF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d5_pulses", 32'(p), 32'd0);
    chk("d5_held",   32'(key_held), 32'd1);
    chk("d5_clean",  32'(keypad_clean), 32'h3EF);
    run(10'h3FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d45_rel_pulses", 32'(p), 32'd0);
    chk("d45_rel_at",     32'(c_at), 32'd22);
    chk("d45_rel_held",   32'(key_held), 32'd0);

    // Reset pulse while digit 9 is held.
    run(10'h1FF, 30, p, f, l, cd, hv, c_at, hc);
    chk("d9_pulses", 32'(p), 32'd1);
    chk("d9_code",   32'(cd), 32'd9);
    rst = 1'b0;
    #1;
    chk("d9_rst_held",  32'(key_held), 32'd0);
    chk("d9_rst_clean", 32'(keypad_clean), 32'h3FF);
    chk("d9_rst_code",  32'(key_code), 32'd0);
    chk("d9_rst_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(10'h1FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d9_re_pulses", 32'(p), 32'd1);
    chk("d9_re_at",     32'(f), 32'd22);
    chk("d9_re_code",   32'(cd), 32'd9);
    run(10'h3FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d9_rel_clean", 32'(keypad_clean), 32'h3FF);

    // Digit 0 held for 800 cycles.
    run(10'h3FE, 800, p, f, l, cd, hv, c_at, hc);
    chk("d0_first_at", 32'(f), 32'd22);
    chk("d0_code",     32'(cd), 32'd0);
`ifdef KEYPAD_REPEAT_EN
    chk("d0_pulses",  32'(p), 32'd4);
    chk("d0_last_at", 32'(l), 32'd722);
`else
    chk("d0_pulses",  32'(p), 32'd1);
    chk("d0_last_at", 32'(l), 32'd22);
`endif
    run(10'h3FF, 40, p, f, l, cd, hv, c_at, hc);
    chk("d0_rel_pulses", 32'(p), 32'd0);
    chk("d0_rel_clean",  32'(keypad_clean), 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
